// File: rtl/cmp_result_monitor.sv
// ---------------------------------------------------------------------------
// cmp_result_monitor
//   Debounces the less/equal/greater flags of a 3-bit magnitude comparator
//   into a registered, glitch-free relation state. Counts committed
//   known->known relation changes (saturating) and flags non-one-hot flag
//   combinations with a sticky error bit.
//
//   Optional feature macro: CMP_MON_ERR_EN
//     defined   : non-one-hot samples set err and restart the debounce run.
//     undefined : err is tied low; non-one-hot samples are ignored as if
//                 in_valid were low.
// ---------------------------------------------------------------------------
module cmp_result_monitor #(
    parameter int DEBOUNCE = 4,   // matching samples needed to commit (1..15)
    parameter int CNT_W    = 8    // width of the change counter
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             L,
    input  logic             E,
    input  logic             G,
    input  logic             clr,
    output logic [1:0]       cur_state,
    output logic             state_valid,
    output logic             change,
    output logic [CNT_W-1:0] change_cnt,
    output logic             err
);

    typedef enum logic [1:0] {
        ST_UNKNOWN = 2'b00,
        ST_LESS    = 2'b01,
        ST_EQUAL   = 2'b10,
        ST_GREATER = 2'b11
    } rel_e;

    localparam logic [3:0]       RUN_MAX = 4'(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Committed relation (FSM state), debounce candidate and run length
    rel_e             state_q, state_d;
    rel_e             cand_q, cand_d;
    logic [3:0]       run_q, run_d;

    // Registered outputs
    logic             state_valid_q, state_valid_d;
    logic             change_q, change_d;
    logic [CNT_W-1:0] change_cnt_q, change_cnt_d;

    // Sample classification
    rel_e             sample_code;
    logic             one_hot;
    logic             legal;
    logic             illegal;
    logic             commit;

    // Decode the raw flags into a relation code and a one-hot indication
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        sample_code = ST_UNKNOWN;
        one_hot     = 1'b0;
        case ({L, E, G})
            3'b100: begin sample_code = ST_LESS;    one_hot = 1'b1; end
            3'b010: begin sample_code = ST_EQUAL;   one_hot = 1'b1; end
            3'b001: begin sample_code = ST_GREATER; one_hot = 1'b1; end
            default: begin sample_code = ST_UNKNOWN; one_hot = 1'b0; end
        endcase
    end

    assign legal = in_valid & one_hot;

`ifdef CMP_MON_ERR_EN
    assign illegal = in_valid & ~one_hot;
`else
    // Without checking, a non-one-hot sample is simply not a sample.
    assign illegal = 1'b0;
`endif

    // Debounce run tracking: extend a matching run, restart on a new code,
    // invalidate on an illegal sample, hold through idle cycles
    always_comb begin
        cand_d = cand_q;
        run_d  = run_q;
        if (legal) begin
            // run_q == 0 means there is no valid candidate to match against
            if ((run_q != 4'd0) && (sample_code == cand_q)) begin
                if (run_q < RUN_MAX) begin
                    run_d = run_q + 4'd1;
                end
            end else begin
                cand_d = sample_code;
                run_d  = 4'd1;
            end
        end else if (illegal) begin
            cand_d = ST_UNKNOWN;
            run_d  = 4'd0;
        end
    end

    // A commit happens on the edge that accepts the DEBOUNCE-th matching
    // sample, and only if it actually moves the committed relation
    assign commit = legal && (run_d == RUN_MAX) && (cand_d != state_q);

    // FSM next state: candidate is always a known relation on a commit, so
    // the committed state can never fall back to UNKNOWN
    always_comb begin
        state_d = state_q;
        if (commit) begin
            state_d = cand_d;
        end
    end

    // Next values of the registered outputs
    always_comb begin
        state_valid_d = state_valid_q | commit;
        // Leaving UNKNOWN is not a relation change
        change_d      = commit && (state_q != ST_UNKNOWN);
        change_cnt_d  = change_cnt_q;
        if (clr) begin
            change_cnt_d = '0;
        end else if (change_d && (change_cnt_q != CNT_MAX)) begin
            change_cnt_d = change_cnt_q + CNT_W'(1);
        end
    end

    // State, debounce and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_UNKNOWN;
            cand_q        <= ST_UNKNOWN;
            run_q         <= 4'd0;
            state_valid_q <= 1'b0;
            change_q      <= 1'b0;
            change_cnt_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q       <= state_d;
            cand_q        <= cand_d;
            run_q         <= run_d;
            state_valid_q <= state_valid_d;
            change_q      <= change_d;
            change_cnt_q  <= change_cnt_d;
        end
    end

`ifdef CMP_MON_ERR_EN
    logic err_q, err_d;

    // Sticky error: an illegal sample sets it even when clr is asserted
    always_comb begin
        err_d = err_q;
        if (illegal) begin
            err_d = 1'b1;
        end else if (clr) begin
            err_d = 1'b0;
        end
    end

    // Error flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign cur_state   = state_q;
    assign state_valid = state_valid_q;
    assign change      = change_q;
    assign change_cnt  = change_cnt_q;

endmodule

// File: tb/tb_cmp_result_monitor.sv
// ---------------------------------------------------------------------------
// tb_cmp_result_monitor
//   Drives two monitor instances (DEBOUNCE=4/CNT_W=8 and DEBOUNCE=1/CNT_W=2)
//   with the same directed and random flag streams and compares every output
//   each cycle with a history-based reference model. Honours CMP_MON_ERR_EN.
// ---------------------------------------------------------------------------
module tb_cmp_result_monitor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, L, E, G, clr;

    logic [1:0] cs_a, cs_b;
    logic       sv_a, sv_b, chg_a, chg_b, err_a, err_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    cmp_result_monitor #(.DEBOUNCE(4), .CNT_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .L(L), .E(E), .G(G),
        .clr(clr), .cur_state(cs_a), .state_valid(sv_a), .change(chg_a),
        .change_cnt(cnt_a), .err(err_a)
    );

    cmp_result_monitor #(.DEBOUNCE(1), .CNT_W(2)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .L(L), .E(E), .G(G),
        .clr(clr), .cur_state(cs_b), .state_valid(sv_b), .change(chg_b),
        .change_cnt(cnt_b), .err(err_b)
    );

    always #5 clk = ~clk;

`ifdef CMP_MON_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam int C_L = 1, C_E = 2, C_G = 3;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: legal samples seen since the last reset or illegal
    // sample; a relation commits when the newest DEBOUNCE entries agree.
    logic [1:0] hist[$];
    int         deb  [2] = '{4, 1};
    int         cmax [2] = '{255, 3};
    logic [1:0] m_st [2];
    logic       m_chg[2];
    int         m_cnt[2];
    logic       m_err[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        hist.delete();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 2'd0; m_chg[i] = 1'b0; m_cnt[i] = 0; m_err[i] = 1'b0;
        end
    endfunction

    function automatic void model_step(input bit v, input bit l, input bit e, input bit g, input bit c);
        bit         oh      = (int'(l) + int'(e) + int'(g)) == 1;
        logic [1:0] code    = l ? 2'd1 : (e ? 2'd2 : 2'd3);
        bit         legal   = v && oh;
        bit         illegal = v && !oh && ERR_EN;
        if (legal) begin
            hist.push_back(code);
            if (hist.size() > 16) void'(hist.pop_front());
        end
        if (illegal) hist.delete();
        for (int i = 0; i < 2; i++) begin
            m_chg[i] = 1'b0;
            if (legal && hist.size() >= deb[i]) begin
                bit agree = 1'b1;
                for (int k = 0; k < deb[i]; k++)
                    if (hist[hist.size() - 1 - k] != code) agree = 1'b0;
                if (agree && code != m_st[i]) begin
                    if (m_st[i] != 2'd0) begin
                        m_chg[i] = 1'b1;
                        if (m_cnt[i] < cmax[i]) m_cnt[i]++;
                    end
                    m_st[i] = code;
                end
            end
            if (c) m_cnt[i] = 0;
            if (illegal) m_err[i] = 1'b1;
            else if (c)  m_err[i] = 1'b0;
        end
    endfunction

    task automatic check_all(input string step);
        check({step, ".a.state"}, 32'(cs_a),  32'(m_st[0]));
        check({step, ".a.valid"}, 32'(sv_a),  32'(m_st[0] != 2'd0));
        check({step, ".a.chg"},   32'(chg_a), 32'(m_chg[0]));
        check({step, ".a.cnt"},   32'(cnt_a), 32'(m_cnt[0]));
        check({step, ".a.err"},   32'(err_a), 32'(m_err[0]));
        check({step, ".b.state"}, 32'(cs_b),  32'(m_st[1]));
        check({step, ".b.valid"}, 32'(sv_b),  32'(m_st[1] != 2'd0));
        check({step, ".b.chg"},   32'(chg_b), 32'(m_chg[1]));
        check({step, ".b.cnt"},   32'(cnt_b), 32'(m_cnt[1]));
        check({step, ".b.err"},   32'(err_b), 32'(m_err[1]));
    endtask

    // One clock: drive at the falling edge, model on the rising edge, compare
    // at the next falling edge.
    task automatic cycle(input string step, input bit v, input bit l, input bit e, input bit g, input bit c);
        in_valid = v; L = l; E = e; G = g; clr = c;
        @(posedge clk);
        model_step(v, l, e, g, c);
        @(negedge clk);
        check_all(step);
    endtask

    task automatic samp(input string step, input int code, input int n);
        for (int i = 0; i < n; i++)
            cycle(step, 1'b1, code == C_L, code == C_E, code == C_G, 1'b0);
    endtask

    task automatic idle(input string step, input int n);
        for (int i = 0; i < n; i++) cycle(step, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic async_reset(input string step);
        in_valid = 1'b0; L = 1'b0; E = 1'b0; G = 1'b0; clr = 1'b0;
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all(step);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check_all({step, ".rel"});
    endtask

    initial begin
        int         code;
        bit         v, l, e, g, c;
        logic [2:0] raw;

        rst_n = 1'b0; in_valid = 1'b0; L = 1'b0; E = 1'b0; G = 1'b0; clr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        #2 rst_n = 1'b1;
        @(negedge clk);

        // UNKNOWN -> EQUAL: valid only, no change pulse or count
        samp("eq4", C_E, 4);
        check("eq4.a.state_const", 32'(cs_a), 32'd2);
        check("eq4.a.cnt_const", 32'(cnt_a), 32'd0);

        // Broken run: 3 G, 1 L, then 4 G commits GREATER
        samp("g3", C_G, 3);
        samp("l1", C_L, 1);
        samp("g4a", C_G, 3);
        check("g4a.a.still_eq", 32'(cs_a), 32'd2);
        samp("g4b", C_G, 1);
        check("g4b.a.gt", 32'(cs_a), 32'd3);
        check("g4b.a.pulse", 32'(chg_a), 32'd1);

        // LESS, then an E run split by an idle gap
        samp("l4", C_L, 4);
        samp("e2a", C_E, 2);
        idle("gap", 5);
        samp("e2b", C_E, 2);
        check("gap.a.eq", 32'(cs_a), 32'd2);

        // Illegal L+G mid-run
        samp("ill.pre", C_G, 2);
        cycle("ill", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        samp("ill.post", C_G, 2);
        samp("ill.fin", C_G, 2);

        // Alternating legal samples on the DEBOUNCE=1 instance: 5 changes,
        // then a 6th together with clr
        samp("alt", C_L, 1); samp("alt", C_G, 1); samp("alt", C_L, 1);
        samp("alt", C_G, 1); samp("alt", C_L, 1);
        check("alt.b.sat", 32'(cnt_b), 32'd3);
        cycle("altclr", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        check("altclr.b.pulse", 32'(chg_b), 32'd1);
        check("altclr.b.cnt0", 32'(cnt_b), 32'd0);

        // Async reset discards a 3-sample run
        samp("rst.l", C_L, 4);
        samp("rst.g3", C_G, 3);
        async_reset("arst");
        samp("post.g3", C_G, 3);
        check("post.g3.a.unk", 32'(cs_a), 32'd0);
        samp("post.g4", C_G, 1);
        check("post.g4.a.gt", 32'(cs_a), 32'd3);
        check("post.g4.a.nopulse", 32'(chg_a), 32'd0);

        // Random traffic with sticky codes so runs actually complete
        code = C_E;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(3) == 0) code = $urandom_range(3, 1);
            v = $urandom_range(4) != 0;
            c = $urandom_range(19) == 0;
            if ($urandom_range(11) == 0) begin
                raw = 3'($urandom_range(7));
                if (raw == 3'b100 || raw == 3'b010 || raw == 3'b001) raw = 3'b111;
                l = raw[2]; e = raw[1]; g = raw[0];
            end else begin
                l = code == C_L; e = code == C_E; g = code == C_G;
            end
            cycle("rand", v, l, e, g, c);
            if (n == 300) async_reset("rand.arst");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
